// File: rtl/softmax_stream_param.sv
// softmax_stream_param
// Frame-based base-2 softmax over a runtime-selectable number of classes.
// Scores are collected into a small buffer while the running maximum is
// tracked. Each score is then turned into 2^(score-max) through a fractional
// LUT plus a shift, and the exponentials are summed. Each class is finally
// normalised by a bit-serial restoring divider and streamed out in input order.

module softmax_stream_param #(
  parameter int IN_W   = 20,
  parameter int FRAC_W = 4,
  parameter int N_MAX  = 16,
  parameter int E_W    = 12,
  parameter int OUT_W  = 11
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       dv_in,
  input  logic signed [IN_W-1:0]     sofin,
  input  logic [$clog2(N_MAX+1)-1:0] cfg_n,
  output logic                       in_ready,
  output logic                       dv_out,
  output logic [OUT_W-1:0]           sofout,
  output logic [$clog2(N_MAX)-1:0]   out_idx,
  output logic                       out_last,
  output logic                       err_drop
);

  localparam int CFG_W = $clog2(N_MAX + 1);
  localparam int IDX_W = $clog2(N_MAX);
  localparam int S_W   = E_W + 1 + $clog2(N_MAX);
  localparam int REM_W = S_W + 1;
  localparam int Q_W   = OUT_W + 1;
  localparam int DC_W  = $clog2(OUT_W + 1);
  localparam int SH_W  = $clog2(E_W + 1);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_EXP  = 2'd1,
    S_DIV  = 2'd2,
    S_OUT  = 2'd3
  } state_e;

  // round(2^12 * 2^(-f/16)); the table is tabulated for FRAC_W=4, E_W=12
  function automatic logic [E_W:0] exp_lut(input logic [FRAC_W-1:0] f);
    logic [E_W:0] v;
    case (f)
      4'd0:    v = 13'd4096;
      4'd1:    v = 13'd3922;
      4'd2:    v = 13'd3756;
      4'd3:    v = 13'd3597;
      4'd4:    v = 13'd3444;
      4'd5:    v = 13'd3298;
      4'd6:    v = 13'd3158;
      4'd7:    v = 13'd3025;
      4'd8:    v = 13'd2896;
      4'd9:    v = 13'd2774;
      4'd10:   v = 13'd2656;
      4'd11:   v = 13'd2543;
      4'd12:   v = 13'd2435;
      4'd13:   v = 13'd2332;
      4'd14:   v = 13'd2233;
      4'd15:   v = 13'd2139;
      default: v = 13'd4096;
    endcase
    return v;
  endfunction

  // Out-of-range class counts fall back to the full buffer depth
  function automatic logic [CFG_W-1:0] legal_n(input logic [CFG_W-1:0] c);
    logic [CFG_W-1:0] r;
    if ((c < CFG_W'(2)) || (c > CFG_W'(N_MAX))) begin
      r = CFG_W'(N_MAX);
    end else begin
      r = c;
    end
    return r;
  endfunction

  // State and datapath registers
  state_e                  state_q,    state_d;
  logic [CFG_W-1:0]        idx_q,      idx_d;
  logic [CFG_W-1:0]        n_q,        n_d;
  logic signed [IN_W-1:0]  max_q,      max_d;
  logic [S_W-1:0]          sum_q,      sum_d;
  logic [IN_W-1:0]         diff_q,     diff_d;
  logic [REM_W-1:0]        rem_q,      rem_d;
  logic [Q_W-1:0]          quo_q,      quo_d;
  logic [DC_W-1:0]         div_cnt_q,  div_cnt_d;
  logic                    in_ready_q, in_ready_d;
  logic                    dv_out_q,   dv_out_d;
  logic [OUT_W-1:0]        sofout_q,   sofout_d;
  logic [IDX_W-1:0]        out_idx_q,  out_idx_d;
  logic                    out_last_q, out_last_d;
  logic                    err_drop_q, err_drop_d;

  // Score / exponential buffer
  logic signed [IN_W-1:0]  buf_mem_q [N_MAX];
  logic                    buf_we_s;
  logic [IDX_W-1:0]        buf_waddr_s;
  logic signed [IN_W-1:0]  buf_wdata_s;
  logic [IDX_W-1:0]        rd_addr_s;
  logic signed [IN_W-1:0]  rd_data_s;

  // Combinational helpers
  logic                    accept_s;
  logic [CFG_W-1:0]        n_first_s;
  logic [CFG_W-1:0]        n_eff_s;
  logic                    last_s;
  logic [IN_W-1:0]         k_s;
  logic [FRAC_W-1:0]       f_s;
  logic [E_W:0]            lut_s;
  logic [E_W:0]            exp_s;
  logic                    ge_s;
  logic [REM_W-1:0]        rem_sub_s;

  assign accept_s  = dv_in & in_ready_q;
  assign n_first_s = legal_n(cfg_n);
  assign last_s    = (idx_q == (n_q - CFG_W'(1)));
  assign k_s       = diff_q >> FRAC_W;
  assign f_s       = diff_q[FRAC_W-1:0];
  assign lut_s     = exp_lut(f_s);
  assign ge_s      = (rem_q >= REM_W'(sum_q));
  assign rd_data_s = buf_mem_q[rd_addr_s];

  // Class count in force for the sample being accepted (first sample latches cfg_n)
  always_comb begin
    if (idx_q == '0) begin
      n_eff_s = n_first_s;
    end else begin
      n_eff_s = n_q;
    end
  end

  // Exponential of a registered distance-from-max: LUT on the fraction, shift by the integer part
  always_comb begin
    if (k_s > IN_W'(E_W)) begin
      exp_s = '0;
    end else begin
      exp_s = lut_s >> k_s[SH_W-1:0];
    end
  end

  // One restoring-division step: subtract the sum when it fits
  always_comb begin
    if (ge_s) begin
      rem_sub_s = rem_q - REM_W'(sum_q);
    end else begin
      rem_sub_s = rem_q;
    end
  end

  // Buffer read address: the class being processed, slot 0 when entering division, next class after an output
  always_comb begin
    rd_addr_s = idx_q[IDX_W-1:0];
    case (state_q)
      S_EXP: begin
        if (idx_q == n_q) begin
          rd_addr_s = '0;
        end else begin
          rd_addr_s = idx_q[IDX_W-1:0];
        end
      end
      S_OUT:   rd_addr_s = IDX_W'(idx_q + CFG_W'(1));
      default: rd_addr_s = idx_q[IDX_W-1:0];
    endcase
  end

  // Next-state and datapath control for LOAD -> EXP -> (DIV -> OUT)* -> LOAD
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    n_d         = n_q;
    max_d       = max_q;
    sum_d       = sum_q;
    diff_d      = diff_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    div_cnt_d   = div_cnt_q;
    in_ready_d  = in_ready_q;
    dv_out_d    = 1'b0;
    sofout_d    = sofout_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    err_drop_d  = err_drop_q | (dv_in & ~in_ready_q);
    buf_we_s    = 1'b0;
    buf_waddr_s = idx_q[IDX_W-1:0];
    buf_wdata_s = sofin;

    case (state_q)
      S_LOAD: begin
        if (accept_s) begin
          buf_we_s = 1'b1;
          if (idx_q == '0) begin
            max_d = sofin;
            n_d   = n_first_s;
          end else if (sofin > max_q) begin
            max_d = sofin;
          end else begin
            max_d = max_q;
          end
          if (idx_q == (n_eff_s - CFG_W'(1))) begin
            state_d    = S_EXP;
            idx_d      = '0;
            in_ready_d = 1'b0;
          end else begin
            idx_d = idx_q + CFG_W'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end

      // Two-stage pipeline: distance is registered for class idx while the
      // exponential of class idx-1 is written back and accumulated.
      S_EXP: begin
        if (idx_q < n_q) begin
          diff_d = max_q - rd_data_s;
        end else begin
          diff_d = diff_q;
        end
        if (idx_q != '0) begin
          buf_we_s    = 1'b1;
          buf_waddr_s = IDX_W'(idx_q - CFG_W'(1));
          buf_wdata_s = IN_W'(exp_s);
          sum_d       = sum_q + S_W'(exp_s);
        end else begin
          sum_d = sum_q;
        end
        if (idx_q == n_q) begin
          state_d   = S_DIV;
          idx_d     = '0;
          rem_d     = REM_W'(rd_data_s[E_W:0]);
          quo_d     = '0;
          div_cnt_d = '0;
        end else begin
          idx_d = idx_q + CFG_W'(1);
        end
      end

      // OUT_W+1 quotient bits, MSB first; the first bit has weight 2^OUT_W
      S_DIV: begin
        quo_d     = {quo_q[Q_W-2:0], ge_s};
        rem_d     = REM_W'({rem_sub_s, 1'b0});
        div_cnt_d = div_cnt_q + DC_W'(1);
        if (div_cnt_q == DC_W'(OUT_W)) begin
          state_d = S_OUT;
        end else begin
          state_d = S_DIV;
        end
      end

      S_OUT: begin
        dv_out_d   = 1'b1;
        out_idx_d  = idx_q[IDX_W-1:0];
        out_last_d = last_s;
        if (quo_q[Q_W-1]) begin
          sofout_d = {OUT_W{1'b1}};
        end else begin
          sofout_d = quo_q[OUT_W-1:0];
        end
        if (last_s) begin
          state_d    = S_LOAD;
          in_ready_d = 1'b1;
          idx_d      = '0;
          max_d      = '0;
          sum_d      = '0;
        end else begin
          state_d   = S_DIV;
          idx_d     = idx_q + CFG_W'(1);
          rem_d     = REM_W'(rd_data_s[E_W:0]);
          quo_d     = '0;
          div_cnt_d = '0;
        end
      end

      default: begin
        state_d    = S_LOAD;
        in_ready_d = 1'b1;
        idx_d      = '0;
      end
    endcase
  end

  // Control and datapath register update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_LOAD;
      idx_q      <= '0;
      n_q        <= CFG_W'(N_MAX);
      max_q      <= '0;
      sum_q      <= '0;
      diff_q     <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      div_cnt_q  <= '0;
      in_ready_q <= 1'b1;
      dv_out_q   <= 1'b0;
      sofout_q   <= '0;
      out_idx_q  <= '0;
      out_last_q <= 1'b0;
      err_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      n_q        <= n_d;
      max_q      <= max_d;
      sum_q      <= sum_d;
      diff_q     <= diff_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      div_cnt_q  <= div_cnt_d;
      in_ready_q <= in_ready_d;
      dv_out_q   <= dv_out_d;
      sofout_q   <= sofout_d;
      out_idx_q  <= out_idx_d;
      out_last_q <= out_last_d;
      err_drop_q <= err_drop_d;
    end
  end

  // Buffer write port; contents need no reset since every frame overwrites what it reads
  always_ff @(posedge clk) begin
    if (buf_we_s) begin
      buf_mem_q[buf_waddr_s] <= buf_wdata_s;
    end
  end

  assign in_ready = in_ready_q;
  assign dv_out   = dv_out_q;
  assign sofout   = sofout_q;
  assign out_idx  = out_idx_q;
  assign out_last = out_last_q;
  assign err_drop = err_drop_q;

endmodule

// File: tb/tb_softmax_stream_param.sv
// Scoreboard bench for softmax_stream_param: directed frames with
// hand-computed probabilities, checked by an independent output monitor.

module tb_softmax_stream_param;

  localparam int IN_W  = 20;
  localparam int OUT_W = 11;
  localparam int CFG_W = 5;
  localparam int IDX_W = 4;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    dv_in = 1'b0;
  logic signed [IN_W-1:0]  sofin = '0;
  logic [CFG_W-1:0]        cfg_n = '0;
  logic                    in_ready;
  logic                    dv_out;
  logic [OUT_W-1:0]        sofout;
  logic [IDX_W-1:0]        out_idx;
  logic                    out_last;
  logic                    err_drop;

  softmax_stream_param dut (
    .clk      (clk),
    .rst      (rst),
    .dv_in    (dv_in),
    .sofin    (sofin),
    .cfg_n    (cfg_n),
    .in_ready (in_ready),
    .dv_out   (dv_out),
    .sofout   (sofout),
    .out_idx  (out_idx),
    .out_last (out_last),
    .err_drop (err_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int val;
    int idx;
    int last;
    int n;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail = 0;
  int   t_acc_last = 0;
  int   prev_pulse = 0;
  int   pulses = 0;
  int   fsum = 0;
  int   fbest = -1;
  int   fbidx = -1;
  int   last_sum = 0;
  int   last_argmax = -1;
  int   p0;
  int   vals[$];
  int   exps[$];

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every output pulse
  always @(negedge clk) begin
    if (!rst && dv_out === 1'b1) begin
      pulses++;
      if (sb.size() == 0) begin
        check("unexpected_dv_out", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("sofout[%0d]", mon_e.idx), int'(sofout), mon_e.val);
        check("out_idx", int'(out_idx), mon_e.idx);
        check("out_last", int'(out_last), mon_e.last);
        if (mon_e.idx == 0) check("first_latency", cyc - t_acc_last, mon_e.n + OUT_W + 3);
        else                check("pulse_spacing", cyc - prev_pulse, OUT_W + 2);
      end
      if (out_idx == '0) begin
        fsum  = 0;
        fbest = -1;
      end
      fsum += int'(sofout);
      if (int'(sofout) > fbest) begin
        fbest = int'(sofout);
        fbidx = int'(out_idx);
      end
      if (out_last) begin
        last_sum    = fsum;
        last_argmax = fbidx;
      end
      prev_pulse = cyc;
    end
  end

  // Present one sample once in_ready is high; gap = idle cycles first
  task automatic send(input int val, input int cfg, input int gap);
    bit done;
    done  = 1'b0;
    dv_in = 1'b0;
    repeat (gap) @(posedge clk);
    for (int w = 0; w < 400; w++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        done = 1'b1;
        break;
      end
    end
    if (done) begin
      dv_in = 1'b1;
      sofin = IN_W'(val);
      cfg_n = CFG_W'(cfg);
      @(posedge clk);
      #1;
      t_acc_last = cyc;
    end else begin
      check("accept_timeout", 0, 1);
    end
    dv_in = 1'b0;
  endtask

  task automatic issue_frame(input int n, input int cfg, input bit gaps);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.val  = exps[i];
      e.idx  = i;
      e.last = (i == n - 1) ? 1 : 0;
      e.n    = n;
      sb.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      send(vals[i], cfg, gaps ? int'($urandom_range(0, 3)) : 0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("drain", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_dv_out",   int'(dv_out),   0);
    check("rst_sofout",   int'(sofout),   0);
    check("rst_out_idx",  int'(out_idx),  0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_err_drop", int'(err_drop), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 13 equal scores: floor(2048/13) each
    vals.delete();
    exps.delete();
    for (int i = 0; i < 13; i++) begin
      vals.push_back(4000);
      exps.push_back(157);
    end
    issue_frame(13, 13, 1'b0);
    drain();
    check("hold_dv_out",   int'(dv_out),   0);
    check("hold_sofout",   int'(sofout),   157);
    check("hold_out_idx",  int'(out_idx),  12);
    check("hold_out_last", int'(out_last), 1);

    // Two classes one LUT step apart: 2/3 and 1/3
    vals = '{100, 84};
    exps = '{1365, 682};
    issue_frame(2, 2, 1'b0);
    drain();

    // Dominant class saturates, far-below classes underflow to zero
    vals = '{0, -4096, -4096, 5000};
    exps = '{0, 0, 0, 2047};
    issue_frame(4, 4, 1'b0);
    drain();

    // Mixed sequence, gapless then with random gaps: identical outputs
    vals = '{667, 286, 502, 846, 113, 454, 870, 568, 389, 408, 884, 763, 6};
    exps = '{0, 0, 0, 226, 0, 0, 640, 0, 0, 0, 1175, 6, 0};
    issue_frame(13, 13, 1'b0);
    drain();
    check("sum_in_range_gapless", int'(last_sum >= 2035 && last_sum <= 2047), 1);
    check("argmax_gapless", last_argmax, 10);
    issue_frame(13, 13, 1'b1);
    drain();
    check("sum_in_range_gapped", int'(last_sum >= 2035 && last_sum <= 2047), 1);
    check("argmax_gapped", last_argmax, 10);

    // Samples offered while busy: sticky error, frame unaffected
    check("err_drop_clear", int'(err_drop), 0);
    vals = '{100, 84};
    exps = '{1365, 682};
    issue_frame(2, 2, 1'b0);
    dv_in = 1'b1;
    sofin = IN_W'(12345);
    repeat (15) @(posedge clk);
    #1;
    dv_in = 1'b0;
    @(negedge clk);
    check("err_drop_set", int'(err_drop), 1);
    drain();
    check("err_drop_sticky", int'(err_drop), 1);
    vals = '{0, -4096, -4096, 5000};
    exps = '{0, 0, 0, 2047};
    issue_frame(4, 4, 1'b0);
    drain();
    check("err_drop_sticky2", int'(err_drop), 1);

    // Reset after 5 of 8 samples: frame abandoned, no output
    for (int i = 0; i < 5; i++) send(9000, 8, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    p0 = pulses;
    repeat (60) @(negedge clk);
    check("no_output_after_reset", pulses - p0, 0);
    check("post_rst_in_ready", int'(in_ready), 1);
    check("post_rst_err_drop", int'(err_drop), 0);
    vals = '{160, 160, 144, 128, 160, 96, 160, 0};
    exps = '{425, 425, 212, 106, 425, 26, 425, 0};
    issue_frame(8, 8, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
